chroma_upsample_stream: RTL and testbench
=========================================

CHROMA_UPSAMPLE_STREAM -- requirements
Module: chroma_upsample_stream

Interface
REQ-001 SHALL have parameter DW, default 9: sample width in bits.
REQ-002 SHALL have parameter CHW, default $clog2(`CH+1): channel-id width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 2: 00 = 4:4:4, 01 = 4:2:2, 10 = 4:2:0, 11 = treated as 4:4:4; sampled only on input accept.
REQ-006 SHALL have port ch_in, input, CHW: channel id (0 = Y, 1 = Cb, 2 = Cr).
REQ-007 SHALL have port valid_in, input, 1: block_in and ch_in are valid.
REQ-008 SHALL have port ready_in, output, 1: the block can accept input.
REQ-009 SHALL have port block_in, input, [7:0][7:0] x DW: input block, indexed [row][col].
REQ-010 SHALL have port valid_out, output, 1: block_out is valid.
REQ-011 SHALL have port ready_out, input, 1: the downstream stage accepts block_out.
REQ-012 SHALL have port block_out, output, [7:0][7:0] x DW: the upsampled 8x8 output block.
REQ-013 SHALL have port blk_idx, output, 2: output block index in raster order (0 TL, 1 TR, 2 BL, 3 BR).
REQ-014 SHALL have port ch_out, output, CHW: the latched ch_in.
REQ-015 SHALL have port last_out, output, 1: this output block is the final one for the accepted input.

Function
REQ-016 SHALL accept an input when valid_in && ready_in on a rising edge, latching block_in, ch_in and mode into a one-block buffer.
REQ-017 SHALL compute block count N per accept: N = 1 if ch_in == 0 or mode is 00/11; N = 2 if mode is 01; N = 4 if mode is 10.
REQ-018 SHALL implement FSM states IDLE and EMIT: IDLE -> EMIT on accept; EMIT -> IDLE on the handshake of the last block with no simultaneous accept; EMIT -> EMIT on the last-block handshake with a simultaneous accept.
REQ-019 SHALL assert valid_out in every EMIT cycle, starting the cycle after accept (latency 1).
REQ-020 SHALL hold blk_idx, block_out, ch_out and last_out stable while valid_out && !ready_out.
REQ-021 SHALL increment blk_idx on each valid_out && ready_out handshake, set last_out = (blk_idx == N-1), and reset blk_idx to 0 after the last block.
REQ-022 SHALL drive ready_in = (state == IDLE) || (valid_out && ready_out && last_out), giving zero-bubble back-to-back blocks.
REQ-023 SHALL, for N = 1, produce out[r][c] = in[r][c].
REQ-024 SHALL, for N = 2, produce out[r][c] = in[r][(c>>1) + 4*k], with k = blk_idx.
REQ-025 SHALL, for N = 4, produce out[r][c] = in[(r>>1) + 4*(k>>1)][(c>>1) + 4*(k&1)].
REQ-026 SHALL pass samples bit-exact with no arithmetic; output width equals DW.
REQ-027 SHALL drive block_out, ch_out, blk_idx and last_out to 0 whenever valid_out is 0.
REQ-028 SHALL ignore valid_in while ready_in is 0; the held buffer is unaffected.
REQ-029 SHALL ignore ready_out while valid_out is 0.

Reset
REQ-030 SHALL, while rst_n = 0, force state to IDLE, blk_idx to 0, valid_out to 0, the buffer to 0 and all outputs to 0, with ready_in = 1 after release.
REQ-031 SHALL, on rst_n assertion mid-EMIT, discard the in-flight block without completing the remaining outputs.
REQ-032 SHALL accept a new input on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL be verified by: ch = 1, mode = 10, in[r][c] = 8r + c + 1, ready_out held at 1 -> 4 consecutive outputs, blk_idx 0..3; blk 0 out[0][0] = 1, out[1][1] = 1, out[0][2] = 2; blk 3 out[7][7] = 64; last_out only on blk 3.
REQ-034 SHALL be verified by: ch = 2, mode = 01 -> 2 outputs; blk 1 out[5][0] = in[5][4], out[5][7] = in[5][7]; then IDLE.
REQ-035 SHALL be verified by: ch = 0, mode = 10 -> exactly 1 output equal to the input, with last_out = 1.
REQ-036 SHALL be verified by: a 4:2:0 block followed by a second block (in + 1) presented with valid_in held high -> 8 outputs in 8 consecutive cycles with no bubble; the second block is accepted on blk 3's handshake.
REQ-037 SHALL be verified by: ready_out = 0 for 3 cycles during blk 1 -> blk_idx, block_out and last_out stay frozen, and ready_in stays 0.
REQ-038 SHALL be verified by: rst_n driven low asynchronously between clock edges during blk 2 -> valid_out falls immediately, and the next accept starts at blk_idx 0.

Source files
------------

// File: rtl/chroma_upsample_stream.sv
// Chroma upsampler for 8x8 sample blocks. Each accepted block is held in a
// one-block buffer and replayed as 1, 2 or 4 output blocks, with every
// source sample replicated horizontally (4:2:2) or in both directions
// (4:2:0). Luma and 4:4:4 blocks pass straight through as a single block.
module chroma_upsample_stream #(
  parameter int DW  = 9,
  // Enough bits for the three channel ids Y, Cb and Cr.
  parameter int CHW = $clog2(3 + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [CHW-1:0]            ch_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [7:0][7:0][DW-1:0]   block_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [7:0][7:0][DW-1:0]   block_out,
  output logic [1:0]                blk_idx,
  output logic [CHW-1:0]            ch_out,
  output logic                      last_out
);

  typedef enum logic {IDLE, EMIT} state_t;
  // Upsampling factor latched with the block: number of output blocks.
  typedef enum logic [1:0] {UP1, UP2, UP4} up_t;

  state_t                    state_q, state_d;
  up_t                       up_q, up_d;
  logic [1:0]                blk_q, blk_d;
  logic [CHW-1:0]            ch_q, ch_d;
  logic [7:0][7:0][DW-1:0]   buf_q, buf_d;

  logic is_last;
  logic fire_out;
  logic accept;

  // Last-block detection for the latched upsampling factor.
  always_comb begin
    is_last = 1'b0;
    case (up_q)
      UP1:     is_last = (blk_q == 2'd0);
      UP2:     is_last = (blk_q == 2'd1);
      default: is_last = (blk_q == 2'd3);
    endcase
  end

  assign valid_out = (state_q == EMIT);
  assign fire_out  = valid_out && ready_out;
  // Accepting on the last handshake lets a new block follow with no bubble.
  assign ready_in  = (state_q == IDLE) || (fire_out && is_last);
  assign accept    = valid_in && ready_in;

  // Next-state logic: accept has priority over finishing the current block.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    up_d    = up_q;
    blk_d   = blk_q;
    ch_d    = ch_q;
    buf_d   = buf_q;
    if (accept) begin
      state_d = EMIT;
      blk_d   = 2'd0;
      ch_d    = ch_in;
      buf_d   = block_in;
      if (ch_in == '0 || mode == 2'b00 || mode == 2'b11) begin
        up_d = UP1;
      end else if (mode == 2'b01) begin
        up_d = UP2;
      end else begin
        up_d = UP4;
      end
    end else if (fire_out && is_last) begin
      state_d = IDLE;
      blk_d   = 2'd0;
    end else if (fire_out) begin
      blk_d = blk_q + 2'd1;
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the block buffer is reset along with the control state so a
    // reset leaves no stale samples behind; it is a register bank, not RAM.
    if (!rst_n) begin
      state_q <= IDLE;
      up_q    <= UP1;
      blk_q   <= 2'd0;
      ch_q    <= '0;
      buf_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from
      // the values computed before the edge.
      state_q <= state_d;
      up_q    <= up_d;
      blk_q   <= blk_d;
      ch_q    <= ch_d;
      buf_q   <= buf_d;
    end
  end

  // Output mapping: pick the source sample for each output position;
  // blk_q[1] selects the bottom half, blk_q[0] the right half.
  always_comb begin
    logic [2:0] sr;
    logic [2:0] sc;
    block_out = '0;
    blk_idx   = 2'd0;
    ch_out    = '0;
    last_out  = 1'b0;
    sr        = 3'd0;
    sc        = 3'd0;
    if (valid_out) begin
      blk_idx  = blk_q;
      ch_out   = ch_q;
      last_out = is_last;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          case (up_q)
            UP1: begin
              sr = 3'(r);
              sc = 3'(c);
            end
            UP2: begin
              sr = 3'(r);
              sc = {blk_q[0], 2'(c >> 1)};
            end
            default: begin
              sr = {blk_q[1], 2'(r >> 1)};
              sc = {blk_q[0], 2'(c >> 1)};
            end
          endcase
          block_out[r][c] = buf_q[sr][sc];
        end
      end
    end
  end

endmodule

// File: tb/tb_chroma_upsample_stream.sv
// Directed bench for chroma_upsample_stream with hand-computed expectations.
module tb_chroma_upsample_stream;

  localparam int DW  = 9;
  localparam int CHW = 2;

  typedef logic [7:0][7:0][DW-1:0] blk_t;
  typedef logic [575:0]            wide_t;

  logic           clk;
  logic           rst_n;
  logic [1:0]     mode;
  logic [CHW-1:0] ch_in;
  logic           valid_in;
  logic           ready_in;
  blk_t           block_in;
  logic           valid_out;
  logic           ready_out;
  blk_t           block_out;
  logic [1:0]     blk_idx;
  logic [CHW-1:0] ch_out;
  logic           last_out;

  int n_checks = 0;
  int n_fail   = 0;

  chroma_upsample_stream #(.DW(DW), .CHW(CHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .ch_in     (ch_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .block_in  (block_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .block_out (block_out),
    .blk_idx   (blk_idx),
    .ch_out    (ch_out),
    .last_out  (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // in[r][c] = 8r + c + 1 + off
  function automatic blk_t make_blk(input int off);
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = DW'(8 * r + c + 1 + off);
    return b;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [CHW-1:0] ch, input logic [1:0] md, input blk_t b);
    ch_in    = ch;
    mode     = md;
    block_in = b;
    valid_in = 1'b1;
  endtask

  initial begin
    int run;
    rst_n     = 1'b0;
    mode      = 2'b00;
    ch_in     = '0;
    valid_in  = 1'b0;
    block_in  = '0;
    ready_out = 1'b1;
    #12;
    check("rst_valid_out", wide_t'(valid_out), wide_t'(0));
    check("rst_block_out", wide_t'(block_out), wide_t'(0));
    check("rst_blk_idx",   wide_t'(blk_idx),   wide_t'(0));
    check("rst_last_out",  wide_t'(last_out),  wide_t'(0));
    rst_n = 1'b1;
    #1;
    check("rst_ready_in", wide_t'(ready_in), wide_t'(1));
    tick();

    // 4:2:0 chroma: four quadrant blocks.
    present(2'd1, 2'b10, make_blk(0));
    tick();
    valid_in = 1'b0;
    check("420_b0_valid",  wide_t'(valid_out),       wide_t'(1));
    check("420_b0_idx",    wide_t'(blk_idx),         wide_t'(0));
    check("420_b0_00",     wide_t'(block_out[0][0]), wide_t'(1));
    check("420_b0_11",     wide_t'(block_out[1][1]), wide_t'(1));
    check("420_b0_02",     wide_t'(block_out[0][2]), wide_t'(2));
    check("420_b0_last",   wide_t'(last_out),        wide_t'(0));
    check("420_b0_rdyin",  wide_t'(ready_in),        wide_t'(0));
    check("420_b0_ch",     wide_t'(ch_out),          wide_t'(1));
    tick();
    check("420_b1_idx",    wide_t'(blk_idx),         wide_t'(1));
    check("420_b1_00",     wide_t'(block_out[0][0]), wide_t'(5));
    check("420_b1_last",   wide_t'(last_out),        wide_t'(0));
    tick();
    check("420_b2_idx",    wide_t'(blk_idx),         wide_t'(2));
    check("420_b2_00",     wide_t'(block_out[0][0]), wide_t'(33));
    check("420_b2_77",     wide_t'(block_out[7][7]), wide_t'(60));
    tick();
    check("420_b3_idx",    wide_t'(blk_idx),         wide_t'(3));
    check("420_b3_77",     wide_t'(block_out[7][7]), wide_t'(64));
    check("420_b3_00",     wide_t'(block_out[0][0]), wide_t'(37));
    check("420_b3_last",   wide_t'(last_out),        wide_t'(1));
    check("420_b3_rdyin",  wide_t'(ready_in),        wide_t'(1));
    tick();
    check("420_done_valid", wide_t'(valid_out), wide_t'(0));
    check("420_done_block", wide_t'(block_out), wide_t'(0));

    // 4:2:2 Cr: two horizontal halves.
    present(2'd2, 2'b01, make_blk(0));
    tick();
    valid_in = 1'b0;
    check("422_b0_50",   wide_t'(block_out[5][0]), wide_t'(41));
    check("422_b0_57",   wide_t'(block_out[5][7]), wide_t'(44));
    check("422_b0_last", wide_t'(last_out),        wide_t'(0));
    check("422_b0_ch",   wide_t'(ch_out),          wide_t'(2));
    tick();
    check("422_b1_idx",  wide_t'(blk_idx),         wide_t'(1));
    check("422_b1_50",   wide_t'(block_out[5][0]), wide_t'(45));
    check("422_b1_57",   wide_t'(block_out[5][7]), wide_t'(48));
    check("422_b1_last", wide_t'(last_out),        wide_t'(1));
    tick();
    check("422_idle", wide_t'(valid_out), wide_t'(0));

    // Luma in 4:2:0 mode passes through as one block.
    present(2'd0, 2'b10, make_blk(0));
    tick();
    valid_in = 1'b0;
    check("y_block", wide_t'(block_out), wide_t'(make_blk(0)));
    check("y_last",  wide_t'(last_out),  wide_t'(1));
    check("y_idx",   wide_t'(blk_idx),   wide_t'(0));
    tick();
    check("y_idle", wide_t'(valid_out), wide_t'(0));

    // Mode 11 on chroma behaves as 4:4:4.
    present(2'd1, 2'b11, make_blk(3));
    tick();
    valid_in = 1'b0;
    check("m11_block", wide_t'(block_out), wide_t'(make_blk(3)));
    check("m11_last",  wide_t'(last_out),  wide_t'(1));
    tick();
    check("m11_idle", wide_t'(valid_out), wide_t'(0));

    // Back-to-back 4:2:0 blocks with valid_in held high.
    present(2'd1, 2'b10, make_blk(0));
    tick();
    block_in = make_blk(1);
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid_out) run++;
      check($sformatf("b2b_idx%0d", i), wide_t'(blk_idx), wide_t'(i % 4));
      if (i == 3) check("b2b_rdyin_b3", wide_t'(ready_in), wide_t'(1));
      if (i == 4) begin
        check("b2b_B_b0_00", wide_t'(block_out[0][0]), wide_t'(2));
        valid_in = 1'b0;
      end
      if (i == 7) check("b2b_B_b3_77", wide_t'(block_out[7][7]), wide_t'(65));
      tick();
    end
    check("b2b_run",  wide_t'(run),       wide_t'(8));
    check("b2b_idle", wide_t'(valid_out), wide_t'(0));

    // Back-pressure during blk 1, with a rival input that must be ignored.
    present(2'd1, 2'b10, make_blk(0));
    tick();
    block_in = make_blk(7);
    tick();
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_idx", i),   wide_t'(blk_idx),         wide_t'(1));
      check($sformatf("stall%0d_00", i),    wide_t'(block_out[0][0]), wide_t'(5));
      check($sformatf("stall%0d_last", i),  wide_t'(last_out),        wide_t'(0));
      check($sformatf("stall%0d_rdyin", i), wide_t'(ready_in),        wide_t'(0));
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    tick();
    check("stall_resume_idx", wide_t'(blk_idx), wide_t'(2));
    tick();
    check("stall_b3_77", wide_t'(block_out[7][7]), wide_t'(64));
    tick();
    check("stall_idle", wide_t'(valid_out), wide_t'(0));

    // Asynchronous reset in the middle of blk 2.
    present(2'd1, 2'b10, make_blk(0));
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    check("arst_pre_idx", wide_t'(blk_idx), wide_t'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", wide_t'(valid_out), wide_t'(0));
    check("arst_block", wide_t'(block_out), wide_t'(0));
    #1;
    rst_n = 1'b1;
    present(2'd1, 2'b10, make_blk(0));
    #1;
    check("arst_rdyin", wide_t'(ready_in), wide_t'(1));
    tick();
    valid_in = 1'b0;
    check("arst_new_valid", wide_t'(valid_out),       wide_t'(1));
    check("arst_new_idx",   wide_t'(blk_idx),         wide_t'(0));
    check("arst_new_00",    wide_t'(block_out[0][0]), wide_t'(1));
    for (int i = 0; i < 4; i++) tick();
    check("arst_final_idle", wide_t'(valid_out), wide_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
